// File: rtl/cv32e40p_fetch_queue.sv
// ---------------------------------------------------------------------------
// cv32e40p_fetch_queue
//
// Instruction prefetch queue between the controller/IF stage and an OBI
// instruction port. It issues word-aligned fetches, tracks outstanding
// transactions, discards responses that belong to a fetch stream abandoned by
// a redirect, and buffers returned words in a small FIFO with a same-cycle
// bypass when the FIFO is empty.
//
// Ports
//   clk, rst_n        core clock / asynchronous active-low reset
//   req_i             fetch enable from the controller
//   branch_i          redirect pulse, target on branch_addr_i (halfword aligned)
//   fetch_valid_o     word available to the IF stage
//   fetch_ready_i     IF stage consumes the presented word
//   fetch_rdata_o     presented word
//   instr_req_o       OBI address phase request
//   instr_addr_o      OBI address (always word aligned)
//   instr_gnt_i       OBI grant
//   instr_rvalid_i    OBI response valid
//   instr_rdata_i     OBI response data
//   busy_o            request pending or responses outstanding
//
// Address-phase FSM
//   state  | meaning
//   IDLE   | no request on the bus
//   REQ    | request to addr_q on the bus
//   REQ_BR | ungranted request to the old address still on the bus; the
//          | redirect target waits in br_addr_q until the grant
// ---------------------------------------------------------------------------
module cv32e40p_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW:0]   C_DEPTH = (CW + 1)'(DEPTH);
  localparam logic [CW:0]   C_INC   = (CW + 1)'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    REQ_BR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q;
  logic [31:0]   br_addr_q;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   mem_q [DEPTH];

  logic        gnt;
  logic        req_hold;
  logic        rv_acc;
  logic        rv_drop;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [CW:0] used;
  logic        can_issue;
  logic        can_issue_more;
  logic [31:0] br_tgt;
  logic        unused_br_lsb;

  assign unused_br_lsb = ^branch_addr_i[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + P_ONE;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake qualifiers and issue credit
  // -------------------------------------------------------------------------
  assign gnt        = instr_req_o & instr_gnt_i;
  assign req_hold   = instr_req_o & ~instr_gnt_i;
  assign rv_drop    = instr_rvalid_i & (discard_q != '0);
  assign rv_acc     = instr_rvalid_i & (discard_q == '0);
  assign fifo_empty = (fifo_cnt == '0);
  assign br_tgt     = {branch_addr_i[31:2], 2'b00};

  // Every granted word keeps a slot reserved (outstanding, then buffered)
  // until the IF stage takes it or it is discarded, so the FIFO cannot
  // overflow. Staying in REQ across a grant must also count the word being
  // granted in this very cycle.
  assign used           = {1'b0, fifo_cnt} + {1'b0, out_q};
  assign can_issue      = req_i & ~branch_i & (used < C_DEPTH);
  assign can_issue_more = req_i & ~branch_i & ((used + C_INC) < C_DEPTH);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (instr_gnt_i) begin
          state_d = can_issue_more ? REQ : IDLE;
        end else if (branch_i) begin
          // An ungranted request cannot be withdrawn; keep it on the bus.
          state_d = REQ_BR;
        end
      end
      REQ_BR: begin
        if (instr_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    instr_req_o  = (state_q == REQ) || (state_q == REQ_BR);
    instr_addr_o = addr_q;
    busy_o       = instr_req_o | (out_q != '0);
  end

  // -------------------------------------------------------------------------
  // Fetch address and redirect target
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      br_addr_q <= '0;
    end else if (branch_i) begin
      if (req_hold) begin
        br_addr_q <= br_tgt;
      end else begin
        addr_q <= br_tgt;
      end
    end else if (gnt) begin
      addr_q <= (state_q == REQ_BR) ? br_addr_q : addr_q + 32'd4;
    end
  end

  // -------------------------------------------------------------------------
  // Outstanding and discard counters
  // -------------------------------------------------------------------------
  always_comb begin
    out_d = out_q;
    if (gnt && !instr_rvalid_i) begin
      out_d = out_q + C_ONE;
    end else if (!gnt && instr_rvalid_i) begin
      out_d = out_q - C_ONE;
    end
  end

  always_comb begin
    discard_d = discard_q;
    if (rv_drop) begin
      discard_d = discard_q - C_ONE;
    end
    // The request held through a redirect belongs to the old stream.
    if ((state_q == REQ_BR) && instr_gnt_i) begin
      discard_d = discard_d + C_ONE;
    end
    // Everything still outstanding after a redirect cycle is stale,
    // including a request granted in that same cycle.
    if (branch_i) begin
      discard_d = out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      discard_q <= '0;
    end else begin
      out_q     <= out_d;
      discard_q <= discard_d;
    end
  end

  // -------------------------------------------------------------------------
  // Response FIFO with empty bypass
  // -------------------------------------------------------------------------
  assign push = rv_acc & ~branch_i & (~fifo_empty | ~fetch_ready_i);
  assign pop  = ~fifo_empty & fetch_ready_i & ~branch_i;

  always_comb begin
    fetch_valid_o = ~branch_i & (~fifo_empty | rv_acc);
    fetch_rdata_o = '0;
    if (!fifo_empty) begin
      fetch_rdata_o = mem_q[rd_ptr_q];
    end else if (rv_acc) begin
      fetch_rdata_o = instr_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= instr_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fifo_cnt <= '0;
    end else if (branch_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + C_ONE;
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - C_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_fetch_queue
//
// Reference model: every granted transaction is tagged with the fetch-stream
// epoch that issued it; a redirect starts a new epoch. A response is
// delivered only if its epoch is current, delivered words queue up in order
// and are consumed by the IF-stage handshake. Requests must appear at the
// model's next-address, be stable until granted and respect the word credit.
// ---------------------------------------------------------------------------
module tb_cv32e40p_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  cv32e40p_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } txn_t;

  txn_t        outq[$];
  logic [31:0] fq[$];
  logic [31:0] gnt_log[$];
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_epoch;
  int          epoch;
  logic [31:0] next_addr;
  logic        prev_req;
  logic        prev_br;

  logic        obs_valid;
  logic [31:0] obs_rdata;
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_busy;
  int          obs_cyc;

  int checks;
  int failures;
  int cyc_n;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Compare DUT outputs against the model for the current cycle, then
  // advance the model by this cycle's events.
  task automatic model_step();
    logic        live;
    logic [31:0] live_data;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic        fq_empty0;
    logic        taken;
    live      = 1'b0;
    live_data = 32'h0;
    if (instr_rvalid_i && outq.size() != 0) begin
      live      = (outq[0].epoch == epoch) && !branch_i;
      live_data = data_of(outq[0].addr);
    end
    fq_empty0 = (fq.size() == 0);
    exp_valid = !branch_i && (!fq_empty0 || live);
    exp_rdata = !fq_empty0 ? fq[0] : live_data;

    chk("fetch_valid", {31'd0, fetch_valid_o}, {31'd0, exp_valid});
    if (exp_valid) chk("fetch_rdata", fetch_rdata_o, exp_rdata);
    chk("busy", {31'd0, busy_o}, {31'd0, instr_req_o || (outq.size() != 0)});

    if (instr_req_o) begin
      if (pend) begin
        chk("req_addr_stable", instr_addr_o, pend_addr);
      end else begin
        chk("req_addr", instr_addr_o, next_addr);
        chk("req_credit", ((fq.size() + outq.size()) < DEPTH) ? 32'd1 : 32'd0, 32'd1);
        chk("req_enable", {31'd0, prev_req & ~prev_br}, 32'd1);
        pend       = 1'b1;
        pend_addr  = next_addr;
        pend_epoch = epoch;
      end
    end else begin
      chk("req_not_withdrawn", {31'd0, pend}, 32'd0);
    end

    obs_valid = fetch_valid_o;
    obs_rdata = fetch_rdata_o;
    obs_req   = instr_req_o;
    obs_addr  = instr_addr_o;
    obs_busy  = busy_o;
    obs_cyc   = cyc_n;

    if (instr_rvalid_i && outq.size() != 0) outq.delete(0);
    taken = exp_valid && fetch_ready_i;
    if (!fq_empty0) begin
      if (taken) fq.delete(0);
      if (live) fq.push_back(live_data);
    end else if (live && !taken) begin
      fq.push_back(live_data);
    end

    if (instr_req_o && instr_gnt_i) begin
      outq.push_back('{addr: pend_addr, epoch: pend_epoch});
      gnt_log.push_back(pend_addr);
      if (pend_epoch == epoch) next_addr = pend_addr + 32'd4;
      pend = 1'b0;
    end
    if (branch_i) begin
      fq.delete();
      epoch++;
      next_addr = {branch_addr_i[31:2], 2'b00};
    end
    chk("fifo_no_overflow", (fq.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
    prev_req = req_i;
    prev_br  = branch_i;
  endtask

  // One clock cycle: drive inputs (called just after a rising edge),
  // check on the falling edge, return just after the next rising edge.
  task automatic cyc(input logic br, input logic [31:0] ba, input logic rq,
                     input logic rdy, input logic g, input logic rv);
    branch_i      = br;
    branch_addr_i = ba;
    req_i         = rq;
    fetch_ready_i = rdy;
    instr_gnt_i   = g & instr_req_o;
    if (rv && outq.size() != 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = data_of(outq[0].addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = $urandom;
    end
    @(negedge clk);
    model_step();
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = 32'h0;
    req_i          = 1'b0;
    fetch_ready_i  = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    outq.delete();
    fq.delete();
    gnt_log.delete();
    pend      = 1'b0;
    pend_addr = 32'h0;
    pend_epoch = 0;
    epoch     = 0;
    next_addr = 32'h0;
    prev_req  = 1'b0;
    prev_br   = 1'b0;
    #3;
    chk("rst_fetch_valid", {31'd0, fetch_valid_o}, 32'd0);
    chk("rst_instr_req", {31'd0, instr_req_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_fetch_rdata", fetch_rdata_o, 32'd0);
    chk("rst_instr_addr", instr_addr_o, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until_valid(input string name, input int max, output logic [31:0] d);
    bit found;
    found = 1'b0;
    d     = 32'h0;
    for (int i = 0; i < max && !found; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      if (obs_valid) begin
        found = 1'b1;
        d     = obs_rdata;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: fetch_valid_o not seen within %0d cycles", name, max);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
    if (gnt_log.size() > idx) chk(name, gnt_log[idx], exp);
    else chk(name, 32'hDEAD_0000 | 32'(gnt_log.size()), exp);
  endtask

  initial begin
    int          t0;
    int          first_v;
    logic [31:0] d;
    logic        last_br;
    logic        br;
    checks   = 0;
    failures = 0;
    cyc_n    = 0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;

    // First fetch without redirect starts at address 0.
    do_reset();
    run_until_valid("boot_no_redirect", 20, d);
    chk("boot_data", d, data_of(32'h0));
    chk_log("boot_first_addr", 0, 32'h0);

    // Streaming after a redirect to 0x80.
    do_reset();
    t0 = cyc_n;
    first_v = -1;
    d = 32'h0;
    cyc(1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      if (obs_valid && first_v < 0) begin
        first_v = obs_cyc - t0;
        d       = obs_rdata;
      end
    end
    chk("stream_valid_latency", 32'(first_v), 32'd3);
    chk("stream_first_data", d, data_of(32'h80));
    chk_log("stream_addr0", 0, 32'h80);
    chk_log("stream_addr1", 1, 32'h84);
    chk_log("stream_addr2", 2, 32'h88);

    // IF stage stalled: FIFO fills, requests stop, then in-order release.
    do_reset();
    cyc(1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("stall_valid", {31'd0, obs_valid}, 32'd1);
    chk("stall_head", obs_rdata, data_of(32'h80));
    chk("stall_req_low", {31'd0, obs_req}, 32'd0);
    chk("stall_busy_low", {31'd0, obs_busy}, 32'd0);
    chk("stall_model_fill", 32'(fq.size()), 32'd2);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("release_word0", obs_rdata, data_of(32'h80));
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("release_word1_valid", {31'd0, obs_valid}, 32'd1);
    chk("release_word1", obs_rdata, data_of(32'h84));

    // Redirect to 0x200 with two responses outstanding.
    do_reset();
    cyc(1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("out2_model_outstanding", 32'(outq.size()), 32'd2);
    chk("out2_busy", {31'd0, obs_busy}, 32'd1);
    chk("out2_req_low", {31'd0, obs_req}, 32'd0);
    cyc(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0);
    run_until_valid("out2_redirect", 20, d);
    chk("out2_next_word", d, data_of(32'h200));
    chk_log("out2_next_addr", 2, 32'h200);

    // Redirect to 0x300 while the request to 0x84 waits 3 cycles for grant.
    do_reset();
    cyc(1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold_req0", {31'd0, obs_req}, 32'd1);
    chk("hold_addr0", obs_addr, 32'h84);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold_addr1", obs_addr, 32'h84);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold_addr2", obs_addr, 32'h84);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("hold_granted_addr", obs_addr, 32'h84);
    run_until_valid("hold_redirect", 20, d);
    chk("hold_next_word", d, data_of(32'h300));
    chk_log("hold_log1", 1, 32'h84);
    chk_log("hold_log2", 2, 32'h300);

    // Halfword-aligned target: the whole word at 0x100 is fetched.
    do_reset();
    cyc(1'b1, 32'h102, 1'b1, 1'b1, 1'b1, 1'b1);
    run_until_valid("half_target", 20, d);
    chk("half_data", d, data_of(32'h100));
    chk_log("half_addr", 0, 32'h100);

    // Address wrap at the top of the space.
    do_reset();
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b1);
    run_until_valid("wrap_target", 20, d);
    chk("wrap_data", d, data_of(32'hFFFF_FFFC));
    repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_log("wrap_addr0", 0, 32'hFFFF_FFFC);
    chk_log("wrap_addr1", 1, 32'h0000_0000);

    // Randomized traffic against the model.
    do_reset();
    last_br = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      br = !last_br && ($urandom_range(0, 24) == 0);
      last_br = br;
      cyc(br, $urandom & 32'hFFFF_FFFE,
          ($urandom_range(0, 7) != 0),
          ((i % 512) < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 1) == 1));
    end

    // Reset in the middle of traffic abandons everything outstanding.
    do_reset();
    run_until_valid("post_reset_fetch", 20, d);
    chk("post_reset_data", d, data_of(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
